// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron datapath and its sequencer.
package snn_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic FUNC_INTEGRATE = 1'b0;
   localparam logic FUNC_LEAK      = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_V,
      LEAK,
      SCAN,
      INTEG,
      WB,
      DONE
   } state_e;

endpackage

// File: rtl/neuron.sv
// Combinational neuron stage: leak (v*(beta+1)>>WIDTH) or saturating integrate.
// A zero-weight integrate is the threshold-check operation: it fires and resets on v >= v_th.
module neuron
   import snn_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] weight,
   input  logic [WIDTH-1:0] v_mem_in,
   input  logic [WIDTH-1:0] beta,
   input  logic [WIDTH-1:0] v_th,
   input  logic             function_sel,
   output logic             spike,
   output logic [WIDTH-1:0] v_mem_out
);

   logic [WIDTH:0]     beta_p1;
   logic [2*WIDTH:0]   prod;
   logic [WIDTH-1:0]   leak_v;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   sat;

   always_comb begin
      beta_p1   = {1'b0, beta} + (WIDTH+1)'(1);
      prod      = (2*WIDTH+1)'(v_mem_in) * (2*WIDTH+1)'(beta_p1);
      leak_v    = WIDTH'(prod >> WIDTH);
      sum       = {1'b0, v_mem_in} + {1'b0, weight};
      sat       = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      spike     = 1'b0;
      v_mem_out = sat;
      if (function_sel == FUNC_LEAK) begin
         v_mem_out = leak_v;
      end else if (weight == '0 && sat >= v_th) begin
         spike     = 1'b1;
         v_mem_out = '0;
      end
   end

endmodule

// File: rtl/neuron_sequencer.sv
// Walks every output neuron of one fully connected layer per timestep:
// leak, integrate active inputs' weights, threshold/write back, record spike.
module neuron_sequencer
   import snn_pkg::*;
#(
   parameter int NUM_INPUTS  = 16,
   parameter int NUM_OUTPUTS = 10,
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int WADDR_W     = $clog2(NUM_INPUTS*NUM_OUTPUTS),
   parameter int VADDR_W     = $clog2(NUM_OUTPUTS)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start_i,
   input  logic [NUM_INPUTS-1:0]  input_spikes_i,
   input  logic [WIDTH-1:0]       beta_i,
   input  logic [WIDTH-1:0]       v_th_i,
   output logic [WADDR_W-1:0]     weight_addr_o,
   input  logic [WIDTH-1:0]       weight_rdata_i,
   output logic [VADDR_W-1:0]     vmem_addr_o,
   input  logic [WIDTH-1:0]       vmem_rdata_i,
   output logic                   vmem_we_o,
   output logic [WIDTH-1:0]       vmem_wdata_o,
   output logic [WIDTH-1:0]       n_weight_o,
   output logic [WIDTH-1:0]       n_v_mem_o,
   output logic [WIDTH-1:0]       n_beta_o,
   output logic [WIDTH-1:0]       n_v_th_o,
   output logic                   n_function_sel_o,
   input  logic                   n_spike_i,
   input  logic [WIDTH-1:0]       n_v_mem_i,
   output logic [NUM_OUTPUTS-1:0] output_spikes_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int IDX_W = $clog2(NUM_INPUTS + 1);

   state_e                 state_q;
   logic [NUM_INPUTS-1:0]  spikes_q;
   logic [WIDTH-1:0]       beta_q;
   logic [WIDTH-1:0]       v_th_q;
   logic [WIDTH-1:0]       v_acc_q;
   logic [IDX_W-1:0]       i_q;
   logic [VADDR_W-1:0]     j_q;
   logic [NUM_OUTPUTS-1:0] out_spikes_q;
   logic                   done_q;
   logic                   cur_spike;

   // Shifting past the top index yields 0, so i == NUM_INPUTS never reads a bit.
   assign cur_spike = |(spikes_q & (NUM_INPUTS'(1) << i_q));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         spikes_q     <= '0;
         beta_q       <= '0;
         v_th_q       <= '0;
         v_acc_q      <= '0;
         i_q          <= '0;
         j_q          <= '0;
         out_spikes_q <= '0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  spikes_q     <= input_spikes_i;
                  beta_q       <= beta_i;
                  v_th_q       <= v_th_i;
                  out_spikes_q <= '0;
                  j_q          <= '0;
                  state_q      <= RD_V;
               end
            end
            RD_V: state_q <= LEAK;
            LEAK: begin
               v_acc_q <= n_v_mem_i;
               i_q     <= '0;
               state_q <= SCAN;
            end
            SCAN: begin
               if (i_q == IDX_W'(NUM_INPUTS)) begin
                  state_q <= WB;
               end else if (cur_spike) begin
                  state_q <= INTEG;
               end else begin
                  i_q <= i_q + IDX_W'(1);
               end
            end
            INTEG: begin
               v_acc_q <= n_v_mem_i;
               i_q     <= i_q + IDX_W'(1);
               state_q <= SCAN;
            end
            WB: begin
               out_spikes_q[j_q] <= n_spike_i;
               if (j_q == VADDR_W'(NUM_OUTPUTS - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  j_q     <= j_q + VADDR_W'(1);
                  state_q <= RD_V;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // RAM data arrives one cycle after the address, so the neuron is fed in the following state.
   always_comb begin
      weight_addr_o    = '0;
      vmem_addr_o      = '0;
      vmem_we_o        = 1'b0;
      vmem_wdata_o     = '0;
      n_weight_o       = '0;
      n_v_mem_o        = '0;
      n_function_sel_o = FUNC_INTEGRATE;
      case (state_q)
         RD_V: vmem_addr_o = j_q;
         LEAK: begin
            n_v_mem_o        = vmem_rdata_i;
            n_function_sel_o = FUNC_LEAK;
         end
         SCAN: begin
            if (cur_spike) begin
               weight_addr_o = WADDR_W'(int'(i_q) * NUM_OUTPUTS + int'(j_q));
            end
         end
         INTEG: begin
            n_v_mem_o  = v_acc_q;
            n_weight_o = weight_rdata_i;
         end
         WB: begin
            n_v_mem_o    = v_acc_q;
            vmem_we_o    = 1'b1;
            vmem_addr_o  = j_q;
            vmem_wdata_o = n_v_mem_i;
         end
         default: ;
      endcase
   end

   assign n_beta_o        = beta_q;
   assign n_v_th_o        = v_th_q;
   assign output_spikes_o = out_spikes_q;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = done_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench: sequencer + neuron + 1-cycle RAMs, checked against a per-neuron arithmetic model.
module tb_neuron_sequencer;
   import snn_pkg::*;

   localparam int NI = 16;
   localparam int NO = 10;
   localparam int W  = 8;
   localparam int WA = $clog2(NI*NO);
   localparam int VA = $clog2(NO);

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_i = 1'b0;
   logic [NI-1:0] input_spikes_i = '0;
   logic [W-1:0]  beta_i = '0;
   logic [W-1:0]  v_th_i = '0;
   logic [WA-1:0] weight_addr_o;
   logic [W-1:0]  weight_rdata_i;
   logic [VA-1:0] vmem_addr_o;
   logic [W-1:0]  vmem_rdata_i;
   logic          vmem_we_o;
   logic [W-1:0]  vmem_wdata_o;
   logic [W-1:0]  n_weight_o, n_v_mem_o, n_beta_o, n_v_th_o;
   logic          n_function_sel_o;
   logic          n_spike_i;
   logic [W-1:0]  n_v_mem_i;
   logic [NO-1:0] output_spikes_o;
   logic          busy_o;
   logic          done_o;

   always #5 clock = ~clock;

   neuron_sequencer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n), .start_i(start_i),
      .input_spikes_i(input_spikes_i), .beta_i(beta_i), .v_th_i(v_th_i),
      .weight_addr_o(weight_addr_o), .weight_rdata_i(weight_rdata_i),
      .vmem_addr_o(vmem_addr_o), .vmem_rdata_i(vmem_rdata_i),
      .vmem_we_o(vmem_we_o), .vmem_wdata_o(vmem_wdata_o),
      .n_weight_o(n_weight_o), .n_v_mem_o(n_v_mem_o), .n_beta_o(n_beta_o),
      .n_v_th_o(n_v_th_o), .n_function_sel_o(n_function_sel_o),
      .n_spike_i(n_spike_i), .n_v_mem_i(n_v_mem_i),
      .output_spikes_o(output_spikes_o), .busy_o(busy_o), .done_o(done_o)
   );

   neuron #(.WIDTH(W)) u_neuron (
      .weight(n_weight_o), .v_mem_in(n_v_mem_o), .beta(n_beta_o), .v_th(n_v_th_o),
      .function_sel(n_function_sel_o), .spike(n_spike_i), .v_mem_out(n_v_mem_i)
   );

   logic [W-1:0] weight_mem [NI*NO];
   logic [W-1:0] vmem [NO];

   always @(posedge clock) begin
      weight_rdata_i <= weight_mem[int'(weight_addr_o)];
      vmem_rdata_i   <= vmem[int'(vmem_addr_o)];
      if (vmem_we_o) vmem[int'(vmem_addr_o)] <= vmem_wdata_o;
   end

   // Event monitor: vmem writes, done pulses and the address behind each consumed weight.
   int           wr_count = 0;
   int           done_count = 0;
   int           addr_log[$];
   logic [WA-1:0] prev_waddr = '0;
   always @(posedge clock) begin
      if (vmem_we_o) wr_count++;
      if (done_o) done_count++;
      if (busy_o && n_function_sel_o == FUNC_INTEGRATE && !vmem_we_o && n_weight_o != '0)
         addr_log.push_back(int'(prev_waddr));
      prev_waddr = weight_addr_o;
   end

   int checks = 0;
   int errors = 0;
   int exp_vmem[NO];

   // Reference: leak once, saturating add of each active weight, then fire-and-reset at v_th.
   task automatic model_step(input logic [NI-1:0] sp, input int beta, input int vth,
                             input int nlim, output logic [NO-1:0] es);
      es = '0;
      for (int j = 0; j < nlim; j++) begin
         int v;
         v = (exp_vmem[j] * (beta + 1)) >> 8;
         for (int i = 0; i < NI; i++)
            if (sp[i]) begin
               v += int'(weight_mem[i*NO + j]);
               if (v > 255) v = 255;
            end
         if (v >= vth) begin
            es[j] = 1'b1;
            v = 0;
         end
         exp_vmem[j] = v;
      end
   endtask

   task automatic run_ts(input logic [NI-1:0] sp, input logic [W-1:0] beta, input logic [W-1:0] vth,
                         output int cyc, output logic [NO-1:0] out_at_start);
      int guard = 0;
      @(posedge clock); #1;
      while (busy_o === 1'b1 && guard < 5000) begin @(posedge clock); #1; guard++; end
      @(negedge clock);
      input_spikes_i = sp; beta_i = beta; v_th_i = vth; start_i = 1'b1;
      @(posedge clock); #1;
      start_i = 1'b0;
      out_at_start = output_spikes_o;
      cyc = 1;
      while (done_o !== 1'b1 && cyc < 5000) begin @(posedge clock); #1; cyc++; end
      $display("timestep spikes=%h beta=%h v_th=%h cycles=%0d out=%b", sp, beta, vth, cyc, output_spikes_o);
   endtask

   task automatic test_reset();
      for (int k = 0; k < NI*NO; k++) weight_mem[k] = 8'h01;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy_o, done_o); end
      checks++; if (output_spikes_o !== '0) begin errors++; $display("FAIL reset_out: got %b want 0", output_spikes_o); end
      checks++; if (vmem_we_o !== 1'b0 || vmem_addr_o !== '0 || weight_addr_o !== '0) begin errors++; $display("FAIL reset_ram_if: we=%b va=%h wa=%h want 0", vmem_we_o, vmem_addr_o, weight_addr_o); end
      checks++; if (n_beta_o !== '0 || n_v_th_o !== '0 || n_v_mem_o !== '0 || n_weight_o !== '0) begin errors++; $display("FAIL reset_neuron_if: nonzero outputs"); end
      @(negedge clock); reset_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_leak_only();
      int cyc; logic [NO-1:0] es, oas;
      for (int j = 0; j < NO; j++) begin vmem[j] <= 8'h40; exp_vmem[j] = 'h40; end
      model_step('0, 'h80, 'hF0, NO, es);
      run_ts('0, 8'h80, 8'hF0, cyc, oas);
      checks++; if (cyc !== NO*(NI+4)+1) begin errors++; $display("FAIL leak_cycles: got %0d want %0d", cyc, NO*(NI+4)+1); end
      checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL leak_spikes: got %b want %b", output_spikes_o, es); end
      checks++; if (n_beta_o !== 8'h80 || n_v_th_o !== 8'hF0) begin errors++; $display("FAIL leak_latched: beta=%h vth=%h want 80 F0", n_beta_o, n_v_th_o); end
      for (int j = 0; j < NO; j++) begin
         checks++; if (vmem[j] !== W'(exp_vmem[j])) begin errors++; $display("FAIL leak_vmem%0d: got %h want %h", j, vmem[j], exp_vmem[j]); end
      end
      @(posedge clock); #1;
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL leak_done_pulse: done=%b busy=%b want 0 0", done_o, busy_o); end
   endtask

   task automatic test_integrate_fire();
      int cyc; logic [NO-1:0] es, oas;
      for (int j = 0; j < NO; j++) begin weight_mem[j] = 8'h10; vmem[j] <= 8'h00; exp_vmem[j] = 0; end
      for (int t = 0; t < 3; t++) begin
         model_step(16'h0001, 'hFF, 'h30, NO, es);
         run_ts(16'h0001, 8'hFF, 8'h30, cyc, oas);
         checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL integ_spikes_t%0d: got %b want %b", t, output_spikes_o, es); end
         for (int j = 0; j < NO; j++) begin
            checks++; if (vmem[j] !== W'(exp_vmem[j])) begin errors++; $display("FAIL integ_vmem_t%0d_%0d: got %h want %h", t, j, vmem[j], exp_vmem[j]); end
         end
      end
      checks++; if (output_spikes_o !== 10'h3FF) begin errors++; $display("FAIL integ_all_fire: got %b want 3ff", output_spikes_o); end
   endtask

   task automatic test_two_inputs();
      int cyc, l0; logic [NO-1:0] es, oas;
      for (int j = 0; j < NO; j++) begin
         weight_mem[j] = 8'h05; weight_mem[15*NO + j] = 8'h07;
         exp_vmem[j] = int'($urandom_range(0, 100)); vmem[j] <= W'(exp_vmem[j]);
      end
      model_step(16'h8001, 'hFF, 'hFF, NO, es);
      l0 = addr_log.size();
      run_ts(16'h8001, 8'hFF, 8'hFF, cyc, oas);
      checks++; if (cyc !== NO*22+1) begin errors++; $display("FAIL two_cycles: got %0d want %0d", cyc, NO*22+1); end
      checks++; if (addr_log.size() - l0 !== 2*NO) begin errors++; $display("FAIL two_addr_count: got %0d want %0d", addr_log.size() - l0, 2*NO); end
      else for (int j = 0; j < NO; j++) begin
         checks++; if (addr_log[l0+2*j] !== j || addr_log[l0+2*j+1] !== 150+j) begin errors++; $display("FAIL two_addr%0d: got %0d,%0d want %0d,%0d", j, addr_log[l0+2*j], addr_log[l0+2*j+1], j, 150+j); end
      end
      for (int j = 0; j < NO; j++) begin
         checks++; if (vmem[j] !== W'(exp_vmem[j])) begin errors++; $display("FAIL two_vmem%0d: got %h want %h", j, vmem[j], exp_vmem[j]); end
      end
   endtask

   task automatic test_random();
      int cyc, l0, ai; logic [NO-1:0] es, oas; logic [NI-1:0] sp; logic [W-1:0] b, th;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NI*NO; k++) weight_mem[k] = W'($urandom_range(1, 40));
         for (int j = 0; j < NO; j++) begin exp_vmem[j] = int'($urandom_range(0, 255)); vmem[j] <= W'(exp_vmem[j]); end
         sp = NI'($urandom); b = W'($urandom); th = W'($urandom_range(64, 255));
         model_step(sp, int'(b), int'(th), NO, es);
         l0 = addr_log.size();
         run_ts(sp, b, th, cyc, oas);
         checks++; if (cyc !== NO*(NI+4+$countones(sp))+1) begin errors++; $display("FAIL rand%0d_cycles: got %0d want %0d", r, cyc, NO*(NI+4+$countones(sp))+1); end
         checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL rand%0d_spikes: got %b want %b", r, output_spikes_o, es); end
         for (int j = 0; j < NO; j++) begin
            checks++; if (vmem[j] !== W'(exp_vmem[j])) begin errors++; $display("FAIL rand%0d_vmem%0d: got %h want %h", r, j, vmem[j], exp_vmem[j]); end
         end
         ai = l0;
         for (int j = 0; j < NO; j++)
            for (int i = 0; i < NI; i++)
               if (sp[i]) begin
                  checks++;
                  if (ai >= addr_log.size() || addr_log[ai] !== i*NO + j) begin errors++; $display("FAIL rand%0d_addr: j=%0d i=%0d got %0d want %0d", r, j, i, (ai < addr_log.size()) ? addr_log[ai] : -1, i*NO + j); end
                  ai++;
               end
      end
   endtask

   task automatic test_start_held();
      int d0, cyc; logic [NO-1:0] es; logic [NI-1:0] sp;
      sp = NI'($urandom);
      for (int j = 0; j < NO; j++) begin exp_vmem[j] = int'($urandom_range(0, 255)); vmem[j] <= W'(exp_vmem[j]); end
      model_step(sp, 'hC0, 'h90, NO, es);
      @(posedge clock); #1;
      d0 = done_count;
      @(negedge clock);
      input_spikes_i = sp; beta_i = 8'hC0; v_th_i = 8'h90; start_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         input_spikes_i = NI'($urandom); beta_i = W'($urandom); v_th_i = W'($urandom);
      end
      start_i = 1'b0;
      cyc = 0;
      while (done_o !== 1'b1 && cyc < 5000) begin @(posedge clock); #1; cyc++; end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", done_o); end
      checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL held_spikes: got %b want %b", output_spikes_o, es); end
      repeat (30) @(posedge clock);
      #1;
      $display("held start: done pulses=%0d out=%b", done_count - d0, output_spikes_o);
      checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL held_done_count: got %0d want 1", done_count - d0); end
      checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL held_spikes_after: got %b want %b", output_spikes_o, es); end
      for (int j = 0; j < NO; j++) begin
         checks++; if (vmem[j] !== W'(exp_vmem[j])) begin errors++; $display("FAIL held_vmem%0d: got %h want %h", j, vmem[j], exp_vmem[j]); end
      end
   endtask

   task automatic test_abort();
      int w0, guard; logic [NO-1:0] es;
      for (int k = 0; k < NI*NO; k++) weight_mem[k] = W'($urandom_range(1, 40));
      for (int j = 0; j < NO; j++) begin exp_vmem[j] = int'($urandom_range(0, 255)); vmem[j] <= W'(exp_vmem[j]); end
      model_step(16'h0F0F, 'hA0, 'hE0, 3, es);
      @(posedge clock); #1;
      w0 = wr_count;
      @(negedge clock);
      input_spikes_i = 16'h0F0F; beta_i = 8'hA0; v_th_i = 8'hE0; start_i = 1'b1;
      @(posedge clock); #1;
      start_i = 1'b0;
      guard = 0;
      while (!(wr_count - w0 == 3 && n_weight_o != '0) && guard < 5000) begin @(posedge clock); #1; guard++; end
      checks++; if (guard >= 5000) begin errors++; $display("FAIL abort_reach_integ: got timeout want INTEG of neuron 3"); end
      reset_n = 1'b0;
      @(posedge clock); #1;
      $display("abort: reset in neuron 3 INTEG, busy=%b out=%b", busy_o, output_spikes_o);
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b done=%b want 0 0", busy_o, done_o); end
      checks++; if (output_spikes_o !== '0) begin errors++; $display("FAIL abort_out: got %b want 0", output_spikes_o); end
      reset_n = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      checks++; if (wr_count - w0 !== 3) begin errors++; $display("FAIL abort_writes: got %0d want 3", wr_count - w0); end
      for (int j = 0; j < NO; j++) begin
         checks++; if (vmem[j] !== W'(exp_vmem[j])) begin errors++; $display("FAIL abort_vmem%0d: got %h want %h", j, vmem[j], exp_vmem[j]); end
      end
   endtask

   task automatic test_last_fires();
      int cyc; logic [NO-1:0] es, oas;
      for (int j = 0; j < NO; j++) begin exp_vmem[j] = (j == NO-1) ? 'h30 : 'h08; vmem[j] <= W'(exp_vmem[j]); end
      model_step('0, 'hFF, 'h20, NO, es);
      run_ts('0, 8'hFF, 8'h20, cyc, oas);
      checks++; if (output_spikes_o !== es || output_spikes_o !== 10'h200) begin errors++; $display("FAIL last_spikes: got %b want %b", output_spikes_o, es); end
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL last_hold%0d: got %b want %b", c, output_spikes_o, es); end
      end
      model_step('0, 'hFF, 'h20, NO, es);
      run_ts('0, 8'hFF, 8'h20, cyc, oas);
      checks++; if (oas !== '0) begin errors++; $display("FAIL last_clear_on_start: got %b want 0", oas); end
      checks++; if (output_spikes_o !== es) begin errors++; $display("FAIL last_second: got %b want %b", output_spikes_o, es); end
      checks++; if (vmem[NO-1] !== W'(exp_vmem[NO-1])) begin errors++; $display("FAIL last_vmem_reset: got %h want %h", vmem[NO-1], exp_vmem[NO-1]); end
   endtask

   initial begin
      test_reset();
      test_leak_only();
      test_integrate_fire();
      test_two_inputs();
      test_random();
      test_start_held();
      test_abort();
      test_last_fires();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
